// File: rtl/me_pkg.sv
// Shared motion-estimation constants: pixel/word sizes, reference walk geometry, fetch FSM states.
// Latency: none (types and constants only).
// Backpressure: n/a.
package me_pkg;

    localparam int PIX_W    = 8;
    localparam int WORD_PIX = 8;
    localparam int WORD_W   = PIX_W * WORD_PIX;

    // Reference-frame walk geometry, shared with the SRAM bank and current-block buffer
    localparam int REF_WORDS_PER_STRIP = 23;
    localparam int REF_STRIPS_PER_BAND = 482;
    localparam int REF_BANDS           = 30;
    localparam int REF_BAND_ROWS       = 16;
    localparam int REF_STRIDE          = 482;
    localparam int REF_AW              = 20;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ref_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rdata whenever not empty, zero when empty.
// Latency: a pushed word reaches rdata one cycle after its push edge.
// Backpressure: pop on empty is ignored; push on full is ignored unless a pop frees the slot.
module ref_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     occ,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since occ guards the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ref_fetch.sv
// Reference-pixel prefetcher: walks the frame in vertical strips, reads words from memory, feeds the SRAM bank.
// Latency: rvalid to ref_in 1 cycle; mem_req/mem_addr registered; primed 1 cycle after the filling push.
// Backpressure: none from the bank; memory reads are credit-limited so occ + outstanding never exceeds DEPTH.
module ref_fetch
    import me_pkg::*;
#(
    parameter int WORDS_PER_STRIP = REF_WORDS_PER_STRIP,
    parameter int STRIPS_PER_BAND = REF_STRIPS_PER_BAND,
    parameter int BANDS           = REF_BANDS,
    parameter int BAND_ROWS       = REF_BAND_ROWS,
    parameter int STRIDE          = REF_STRIDE,
    parameter int AW              = REF_AW,
    parameter int DEPTH           = 8,
    parameter int PRIME_LVL       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    output logic [WORD_W-1:0] ref_in,
    output logic              primed,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              frame_done,
    output logic              underflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = (WORDS_PER_STRIP > 1) ? $clog2(WORDS_PER_STRIP) : 1;
    localparam int SW = (STRIPS_PER_BAND > 1) ? $clog2(STRIPS_PER_BAND) : 1;
    localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1;

    localparam logic [RW-1:0] R_LAST    = RW'(WORDS_PER_STRIP - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(STRIPS_PER_BAND - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(BANDS - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(STRIDE);
    localparam logic [AW-1:0] BAND_STEP = AW'(BAND_ROWS * STRIDE);
    localparam logic [CW-1:0] PRIME_OCC = CW'(PRIME_LVL);
    localparam logic [CW:0]   CREDITS   = (CW+1)'(DEPTH);

    // Walk position; strip_base/band_base hold the first-row address of the
    // current strip and band so every step is an add, never a multiply
    logic [RW-1:0] r;
    logic [SW-1:0] s;
    logic [BW-1:0] b;
    logic [AW-1:0] strip_base;
    logic [AW-1:0] band_base;

    logic [CW-1:0] occ;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] occ_next;
    logic [CW-1:0] out_next;
    logic [CW:0]   inflight_next;
    logic          empty;
    logic          full;
    logic          accept;
    logic          pop_ok;
    logic          push_ok;
    fetch_state_t  state;

    assign accept  = mem_req & mem_ack;
    assign pop_ok  = read_en & ~empty;
    assign push_ok = mem_rvalid & (~full | pop_ok);

    ref_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_rvalid),
        .wdata (mem_rdata),
        .pop   (read_en),
        .rdata (ref_in),
        .occ   (occ),
        .empty (empty),
        .full  (full)
    );

    // Post-edge occupancy and in-flight count, used for the credit and priming decisions
    always_comb begin
        occ_next = occ;
        out_next = outstanding;
        case ({push_ok, pop_ok})
            2'b10:   occ_next = occ + 1'b1;
            2'b01:   occ_next = occ - 1'b1;
            default: occ_next = occ;
        endcase
        case ({accept, mem_rvalid})
            2'b10:   out_next = outstanding + 1'b1;
            2'b01:   out_next = outstanding - 1'b1;
            default: out_next = outstanding;
        endcase
        inflight_next = {1'b0, occ_next} + {1'b0, out_next};
    end

    // Credit tracking: request only while every possible return has a FIFO slot
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            mem_req     <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            outstanding <= out_next;
            mem_req     <= (inflight_next < CREDITS);
            if (read_en & empty & ~mem_rvalid) begin
                underflow <= 1'b1;
            end
        end
    end

    // Address walk: row, then strip, then band; wrap to the frame origin after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            r          <= '0;
            s          <= '0;
            b          <= '0;
            strip_base <= '0;
            band_base  <= '0;
            mem_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (r != R_LAST) begin
                    r        <= r + 1'b1;
                    mem_addr <= mem_addr + ROW_STEP;
                end else begin
                    r <= '0;
                    if (s != S_LAST) begin
                        s          <= s + 1'b1;
                        strip_base <= strip_base + AW'(1);
                        mem_addr   <= strip_base + AW'(1);
                    end else begin
                        s <= '0;
                        if (b != B_LAST) begin
                            b          <= b + 1'b1;
                            band_base  <= band_base + BAND_STEP;
                            strip_base <= band_base + BAND_STEP;
                            mem_addr   <= band_base + BAND_STEP;
                        end else begin
                            b          <= '0;
                            band_base  <= '0;
                            strip_base <= '0;
                            mem_addr   <= '0;
                            frame_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Fill/stream FSM: primed latches once the buffer first reaches the priming level
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            primed <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (occ_next >= PRIME_OCC) begin
                        state  <= STREAM;
                        primed <= 1'b1;
                    end
                end
                STREAM: begin
                    primed <= 1'b1;
                end
                default: begin
                    state  <= FILL;
                    primed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ref_fetch.sv
// Bench for ref_fetch: default-geometry instance against a queue-based memory/FIFO model, plus a small-geometry walk.
// Latency: model memory returns LAT cycles after accept.
// Backpressure: bench reads only when the model FIFO holds data, except the deliberate underflow step.
module tb_ref_fetch;

    localparam int W     = 23;
    localparam int S     = 482;
    localparam int B     = 30;
    localparam int BR    = 16;
    localparam int STR   = 482;
    localparam int DEP   = 8;
    localparam int PRIME = 6;
    localparam int LAT   = 2;
    localparam int FRAME = W * S * B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default geometry
    logic        rst = 1'b1, read_en = 1'b0, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0, ref_in;
    logic        primed, mem_req, frame_done, underflow;
    logic [19:0] mem_addr;

    // Instance B: small geometry
    logic        rst_b = 1'b1, read_en_b = 1'b0, mem_ack_b = 1'b0, mem_rvalid_b = 1'b0;
    logic [63:0] mem_rdata_b = '0, ref_in_b;
    logic        primed_b, mem_req_b, frame_done_b, underflow_b;
    logic [19:0] mem_addr_b;

    ref_fetch dut_a (
        .clk(clk), .rst(rst), .read_en(read_en), .ref_in(ref_in), .primed(primed),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .frame_done(frame_done), .underflow(underflow)
    );

    ref_fetch #(
        .WORDS_PER_STRIP(3), .STRIPS_PER_BAND(2), .BANDS(2), .BAND_ROWS(2), .STRIDE(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .read_en(read_en_b), .ref_in(ref_in_b), .primed(primed_b),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b), .mem_rvalid(mem_rvalid_b),
        .mem_rdata(mem_rdata_b), .frame_done(frame_done_b), .underflow(underflow_b)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
    } ret_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          k      = 0;
    ret_t        memq[$];
    logic [63:0] fifo[$];
    logic [19:0] obs_addr[$];
    logic [63:0] delivered[$];
    bit          exp_req = 0, exp_primed = 0, exp_uf = 0, exp_fd = 0;
    logic [19:0] small_seq[14] = '{20'd0, 20'd4, 20'd8, 20'd1, 20'd5, 20'd9, 20'd8,
                                   20'd12, 20'd16, 20'd9, 20'd13, 20'd17, 20'd0, 20'd4};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Word n of the walk, by direct position arithmetic
    function automatic logic [19:0] addr_of(input int n);
        int rr, ss, bb;
        rr = n % W;
        ss = (n / W) % S;
        bb = (n / (W * S)) % B;
        return 20'((bb * BR + rr) * STR + ss);
    endfunction

    function automatic logic [63:0] data_of(input int n);
        return {32'hA5A5_0000 ^ 32'(n), 12'h0, addr_of(n)};
    endfunction

    // One clock of instance A: drive inputs, clock, advance the model, compare every output
    task automatic tick(input bit ack_i, input bit rd_i, input bit rst_i);
        bit   rv, acc;
        ret_t e;
        rst     = rst_i;
        mem_ack = ack_i;
        read_en = rd_i;
        rv = (memq.size() > 0) && (memq[0].due <= cyc);
        mem_rvalid = rv;
        mem_rdata  = rv ? memq[0].data : {$urandom, $urandom};
        acc = exp_req && ack_i && !rst_i;
        if (acc) obs_addr.push_back(mem_addr);
        @(posedge clk);
        @(negedge clk);
        if (rst_i) begin
            memq.delete(); fifo.delete(); obs_addr.delete();
            k = 0; exp_req = 0; exp_primed = 0; exp_uf = 0; exp_fd = 0;
        end else begin
            exp_fd = 0;
            if (acc) begin
                e.due  = cyc + LAT;
                e.data = data_of(k);
                memq.push_back(e);
                k++;
                if (k % FRAME == 0) exp_fd = 1;
            end
            if (rd_i) begin
                if (fifo.size() > 0) void'(fifo.pop_front());
                else if (!rv) exp_uf = 1;
            end
            if (rv) begin
                e = memq.pop_front();
                fifo.push_back(e.data);
            end
            if (fifo.size() >= PRIME) exp_primed = 1;
            exp_req = (fifo.size() + memq.size()) < DEP;
        end
        cyc++;
        chk("mem_req", 64'(mem_req), 64'(exp_req));
        chk("mem_addr", 64'(mem_addr), 64'(addr_of(k)));
        chk("primed", 64'(primed), 64'(exp_primed));
        chk("underflow", 64'(underflow), 64'(exp_uf));
        chk("frame_done", 64'(frame_done), 64'(exp_fd));
        chk("ref_in", ref_in, (fifo.size() > 0) ? fifo[0] : 64'h0);
        chk("occ", 64'(dut_a.occ), 64'(fifo.size()));
    endtask

    // Small geometry: memory always accepts, returns next cycle, bank reads whenever data is buffered
    task automatic run_small();
        ret_t        bq[$];
        logic [63:0] bf[$];
        ret_t        e;
        int          nacc, t;
        bit          rv, rd, acc, fd_exp;
        nacc = 0;
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b     = 1'b0;
        mem_ack_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            t  = i;
            rv = (bq.size() > 0) && (bq[0].due <= t);
            rd = (bf.size() > 0);
            mem_rvalid_b = rv;
            mem_rdata_b  = rv ? bq[0].data : 64'h0;
            read_en_b    = rd;
            if (rd) chk("small_ref_in", ref_in_b, bf[0]);
            acc    = mem_req_b;
            fd_exp = 0;
            if (acc) begin
                if (nacc < 14) chk("small_addr", 64'(mem_addr_b), 64'(small_seq[nacc]));
                e.due  = t + 1;
                e.data = 64'(nacc) * 64'h0001_0001;
                bq.push_back(e);
                fd_exp = (nacc % 12 == 11);
                nacc++;
            end
            @(posedge clk);
            @(negedge clk);
            if (rd) void'(bf.pop_front());
            if (rv) begin
                e = bq.pop_front();
                bf.push_back(e.data);
            end
            chk("small_frame_done", 64'(frame_done_b), 64'(fd_exp));
        end
        chk("small_underflow", 64'(underflow_b), 64'h0);
        chk("small_accepts_ge14", 64'(nacc >= 14), 64'h1);
    endtask

    initial begin
        logic [63:0] nxt;
        @(negedge clk);

        // Reset: all outputs quiet
        repeat (3) tick(0, 0, 1);

        // Fill with no demand: 8 requests, strip column addresses, priming at 6
        repeat (20) tick(1, 0, 0);
        chk("fill_req_count", 64'(obs_addr.size()), 64'd8);
        for (int i = 0; i < 8 && i < obs_addr.size(); i++)
            chk("fill_addr", 64'(obs_addr[i]), 64'(i * STR));
        chk("fill_req_low", 64'(mem_req), 64'h0);

        // Stream 23 words back to back
        for (int i = 0; i < 23; i++) begin
            delivered.push_back(ref_in);
            tick(1, 1, 0);
        end
        for (int i = 0; i < 23; i++)
            chk("stream_word", delivered[i], data_of(i));
        chk("stream_underflow", 64'(underflow), 64'h0);
        chk("next_strip_addr", (obs_addr.size() > 23) ? 64'(obs_addr[23]) : 64'hFFFF_FFFF, 64'd1);

        // Random memory acceptance and bank demand
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, (fifo.size() > 0) && ($urandom_range(0, 1) == 1), 0);

        // Drain, then read on empty
        for (int i = 0; i < 40 && (fifo.size() > 0 || memq.size() > 0); i++)
            tick(0, fifo.size() > 0, 0);
        tick(0, 1, 0);
        chk("uf_set", 64'(underflow), 64'h1);
        chk("uf_ref_in", ref_in, 64'h0);
        chk("uf_occ", 64'(dut_a.occ), 64'h0);
        repeat (3) tick(0, 0, 0);
        chk("uf_sticky", 64'(underflow), 64'h1);
        tick(1, 0, 0);
        for (int i = 0; i < 10 && memq.size() > 0; i++) tick(0, 0, 0);
        chk("uf_next_push", ref_in, data_of(k - 1));

        // Simultaneous push and pop at occ 1
        tick(1, 0, 0);
        for (int i = 0; i < 10 && !((memq.size() > 0) && (memq[0].due <= cyc)); i++) tick(0, 0, 0);
        nxt = (memq.size() > 0) ? memq[0].data : 64'h0;
        tick(0, 1, 0);
        chk("pp_occ", 64'(dut_a.occ), 64'd1);
        chk("pp_head", ref_in, nxt);
        chk("pp_outstanding", 64'(dut_a.outstanding), 64'(memq.size()));

        // Reset mid-strip with five words buffered
        for (int i = 0; i < 20 && fifo.size() != 5; i++)
            tick((fifo.size() + memq.size()) < 5, 0, 0);
        chk("pre_rst_occ", 64'(dut_a.occ), 64'd5);
        tick(0, 0, 1);
        chk("rst_occ", 64'(dut_a.occ), 64'h0);
        chk("rst_primed", 64'(primed), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_state", 64'(dut_a.state), 64'(me_pkg::FILL));
        repeat (12) tick(1, 0, 0);
        chk("rst_walk0", (obs_addr.size() > 1) ? 64'(obs_addr[0]) : 64'hFFFF_FFFF, 64'd0);
        chk("rst_walk1", (obs_addr.size() > 1) ? 64'(obs_addr[1]) : 64'hFFFF_FFFF, 64'd482);

        // Small geometry walk and frame wrap
        run_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
